alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 ALU_LAT, 1, cycles from alu_en strobe to the alu_y sample edge; legal range 1..7.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester command valid; bit n belongs to requester n.
REQ-005 req_ready  output  2  per-requester command accept; at most one bit high per cycle.
REQ-006 req_op  input  8  4-bit opcode per requester; requester n uses [4n+3:4n].
REQ-007 req_data  input  16  8-bit signed operand per requester; requester n uses [8n+7:8n].
REQ-008 req_lock  input  2  hold grant after this command; meaningful only with REQ-026.
REQ-009 alu_sel  output  4  opcode driven to the ALU.
REQ-010 alu_data  output  8  operand driven to the ALU.
REQ-011 alu_en  output  1  single-cycle execute strobe.
REQ-012 alu_y  input  8  signed ALU result.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer ready.
REQ-015 rsp_data  output  8  captured alu_y.
REQ-016 rsp_id  output  1  requester that issued the responded command.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP only.
REQ-018 IDLE SHALL do the following:
- If any req_valid bit is high, assert req_ready for the winner combinationally.
- Capture op, data and id into holding registers.
- Go to ISSUE.
- req_ready SHALL be 0 in all other states.
REQ-019 Arbitration SHALL be round-robin:
- A single valid requester wins.
- If both are valid, the requester named by the priority pointer wins.
- After each grant, the pointer moves to the other requester.
REQ-020 ISSUE SHALL assert alu_en for exactly one cycle, load the wait counter with ALU_LAT, then go to WAIT.
REQ-021 alu_sel and alu_data SHALL come from the holding registers and stay stable from ISSUE until WAIT exits; outside that window they SHALL hold their last value.
REQ-022 WAIT SHALL decrement the counter, capture alu_y into rsp_data on the edge where the counter reaches 0, and then go to RESP, so alu_y is sampled exactly ALU_LAT edges after the alu_en edge.
REQ-023 RESP SHALL assert rsp_valid with rsp_data and rsp_id stable, and SHALL return to IDLE on the cycle where rsp_ready is high; throughput is one command per 3+ALU_LAT cycles at best.
REQ-024 Opcodes SHALL pass through unmodified.
- Every accepted command SHALL produce exactly one response, including the state-only opcodes 1101, 1110 and 1111.
- For those opcodes the response SHALL carry the sampled alu_y.

Reset
REQ-025 Reset SHALL act immediately and asynchronously, in any state including mid-WAIT, with these effects:
- All outputs go to 0; state goes to IDLE.
- The pointer goes to requester 0; the counter and lock flag are cleared.
- Any in-flight command is dropped with no response, and alu_en is not reasserted for it.

Configuration
REQ-026 Behaviour with ALU_SCHED_LOCK_EN defined:
- Accepting a command with req_lock[id]=1 sets a lock flag.
- While the lock is set, IDLE SHALL grant only the locked requester, stalling in IDLE while that requester's valid is low.
- The lock SHALL clear when the same requester's command with req_lock=0 is accepted.
REQ-027 Without ALU_SCHED_LOCK_EN, req_lock SHALL be ignored, no lock flag SHALL exist, and arbitration is pure round-robin.

Structure
REQ-028 Shared package alu_sched_pkg SHALL hold:
- Opcode constants OP_ADD=0000 through OP_LOAD=1111.
- The state enum typedef.
- Constant REQ_N=2.
REQ-029 The 2-way round-robin pointer/grant logic SHALL be sub-module rr_arb2; all other logic SHALL be inline.

Verification
REQ-030 Single command: reset, then req_valid=01, op=1111, data=0x05.
- req_ready=01 for one cycle.
- One alu_en pulse with alu_sel=1111 and alu_data=0x05.
- rsp_valid with rsp_id=0 exactly 2+ALU_LAT cycles after accept.
REQ-031 Fairness: both requesters continuously valid, rsp_ready=1.
- Grants and rsp_id alternate 0,1,0,1.
- No gap longer than 3+ALU_LAT cycles.
REQ-032 Backpressure: ALU model returns 0xF6, rsp_ready held low 5 cycles.
- rsp_valid=1 and rsp_data=0xF6 held throughout.
- req_ready stays 00 until the handshake completes.
REQ-033 Reset in WAIT: assert reset.
- All outputs read 0 the same cycle and no response ever appears.
- With both valid after release, requester 0 is granted.
REQ-034 Lock: requester 1 sends three commands with lock=1,1,0 while requester 0 stays valid.
- With ALU_SCHED_LOCK_EN, grant order is 1,1,1,0.
- Without it, grant order is 1,0,1,0.
REQ-035 Latency with ALU_LAT=3: model changes alu_y 0x11->0x22 two edges after alu_en and ->0x33 three edges after.
- rsp_data=0x33.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared opcodes, FSM state type and requester count for alu_scheduler
package alu_sched_pkg;

  localparam int REQ_N = 2;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_SHL   = 4'b0110,
    OP_SHR   = 4'b0111,
    OP_ASR   = 4'b1000,
    OP_ROL   = 4'b1001,
    OP_ROR   = 4'b1010,
    OP_MUL   = 4'b1011,
    OP_CMP   = 4'b1100,
    OP_CLR   = 4'b1101,
    OP_STORE = 4'b1110,
    OP_LOAD  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// rtl/alu_scheduler_rr_arb2.sv - two-way round-robin grant with priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    gnt_id = gnt[1];
    ptr_d  = ptr_q;
    // Pointer hands priority to the requester that just lost
    if (advance && (req != 2'b00)) begin
      ptr_d = ~gnt_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - arbitrates two requesters onto a fixed-latency ALU and returns responses
// Optional sticky grant via req_lock is built when ALU_SCHED_LOCK_EN is defined.
module alu_scheduler import alu_sched_pkg::*; #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_op,
  input  logic [15:0] req_data,
  input  logic [1:0] req_lock,
  output logic [3:0] alu_sel,
  output logic [7:0] alu_data,
  output logic       alu_en,
  input  logic [7:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id
);

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic             id_q, id_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [REQ_N-1:0] eligible;
  logic [REQ_N-1:0] gnt;
  logic             gnt_id;
  logic             accept;

`ifdef ALU_SCHED_LOCK_EN
  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;

  assign eligible = lock_q ? (req_valid & (lock_id_q ? 2'b10 : 2'b01)) : req_valid;
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign eligible    = req_valid;
`endif

  assign accept = (state_q == ST_IDLE) && (eligible != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'd0;
      data_q     <= 8'd0;
      id_q       <= 1'b0;
      cnt_q      <= 3'd0;
      rsp_data_q <= 8'd0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef ALU_SCHED_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Only the locked requester can be granted, so its req_lock alone decides the next lock
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d    = req_lock[gnt_id];
      lock_id_d = gnt_id;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == 3'd1) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    data_d     = data_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = gnt_id ? req_op[7:4] : req_op[3:0];
          data_d = gnt_id ? req_data[15:8] : req_data[7:0];
          id_d   = gnt_id;
        end
      end
      ST_ISSUE: cnt_d = LAT;
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Counter hits zero on this edge: ALU_LAT edges after the alu_en edge
        if (cnt_q == 3'd1) begin
          rsp_data_d = alu_y;
          rsp_id_d   = id_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if ((state_q == ST_IDLE) && !reset) begin
      req_ready = gnt;
    end
    alu_en    = (state_q == ST_ISSUE);
    rsp_valid = (state_q == ST_RESP);
  end

  assign alu_sel  = op_q;
  assign alu_data = data_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - directed self-checking bench for alu_scheduler (ALU_LAT=3)
module tb_alu_scheduler;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [7:0]  req_op = 8'h00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_lock = 2'b00;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_data;
  logic        alu_en;
  logic [7:0]  alu_y;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        rsp_id;

  int checks = 0;
  int failures = 0;

  logic [2:0] age;
  logic       y_mode = 1'b0;

  alu_scheduler #(.ALU_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .alu_sel   (alu_sel),
    .alu_data  (alu_data),
    .alu_en    (alu_en),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  // ALU model: age is 1 in the cycle after the alu_en edge, LAT in the cycle before the sample edge
  always @(posedge clk or posedge reset) begin
    if (reset) age <= 3'd0;
    else if (alu_en) age <= 3'd1;
    else if (age != 3'd7) age <= age + 3'd1;
  end

  always_comb begin
    alu_y = 8'h00;
    if (!y_mode) begin
      alu_y = (age == 3'(LAT)) ? alu_data + 8'h01 : 8'hEE;
    end else begin
      case (age)
        3'd0:    alu_y = 8'h00;
        3'd1:    alu_y = 8'h11;
        3'd2:    alu_y = 8'h22;
        3'd3:    alu_y = 8'h33;
        default: alu_y = 8'h44;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int cyc;
    cyc = 0;
    while (!rsp_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    check({tag, "_rsp_seen"}, 16'(rsp_valid), 16'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 16'(req_ready), 16'd0);
    check({tag, "_alu_sel"},   16'(alu_sel),   16'd0);
    check({tag, "_alu_data"},  16'(alu_data),  16'd0);
    check({tag, "_alu_en"},    16'(alu_en),    16'd0);
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "_rsp_data"},  16'(rsp_data),  16'd0);
    check({tag, "_rsp_id"},    16'(rsp_id),    16'd0);
  endtask

  initial begin
    int n_en;
    int lat;
    int multi;
    int n1;
    int stray;
    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    int r_dat[$];
    int exp_lock[4];

    // Reset state, with requests pending to prove req_ready is held low
    req_valid = 2'b11;
    @(negedge clk);
    tick();
    check_all_zero("reset");

    // Single command from requester 0, opcode 1111
    reset = 1'b0;
    req_valid = 2'b01;
    req_op = 8'h0F;
    req_data = 16'h0005;
    #1;
    check("single_ready", 16'(req_ready), 16'b01);
    n_en = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (alu_en) n_en++;
      if (i == 1) begin
        check("single_alu_en", 16'(alu_en), 16'd1);
        check("single_sel", 16'(alu_sel), 16'hF);
        check("single_data", 16'(alu_data), 16'h05);
        check("single_ready_after", 16'(req_ready), 16'b00);
        req_valid = 2'b00;
      end
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    check("single_latency", 16'(lat), 16'(2 + LAT));
    check("single_en_count", 16'(n_en), 16'd1);
    check("single_rsp_data", 16'(rsp_data), 16'h06);
    check("single_rsp_id", 16'(rsp_id), 16'd0);
    tick();
    check("single_rsp_done", 16'(rsp_valid), 16'd0);

    // Fairness from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_op = 8'h21;
    req_data = 16'h2010;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    multi = 0;
    for (int c = 0; c < 80 && r_id.size() < 4; c++) begin
      #1;
      if (req_ready == 2'b11) multi++;
      if (req_ready != 2'b00) begin
        g_id.push_back(int'(req_ready[1]));
        g_cyc.push_back(c);
      end
      if (rsp_valid && rsp_ready) begin
        r_id.push_back(int'(rsp_id));
        r_dat.push_back(int'(rsp_data));
      end
      tick();
      if (g_id.size() >= 4) req_valid = 2'b00;
    end
    check("fair_grant_count", 16'(g_id.size()), 16'd4);
    check("fair_rsp_count", 16'(r_id.size()), 16'd4);
    check("fair_onehot", 16'(multi), 16'd0);
    if (g_id.size() == 4 && r_id.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("fair_grant%0d", i), 16'(g_id[i]), 16'(i % 2));
        check($sformatf("fair_rsp_id%0d", i), 16'(r_id[i]), 16'(i % 2));
        check($sformatf("fair_rsp_data%0d", i), 16'(r_dat[i]), (i % 2 == 1) ? 16'h21 : 16'h11);
        if (i > 0) check($sformatf("fair_gap%0d", i), 16'(g_cyc[i] - g_cyc[i-1]), 16'(3 + LAT));
      end
    end

    // Backpressure: pointer is back on requester 0
    req_op = 8'h00;
    req_data = 16'hF5F5;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    #1;
    check("bp_ready", 16'(req_ready), 16'b01);
    tick();
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 16'(rsp_valid), 16'd1);
      check($sformatf("bp_data%0d", i), 16'(rsp_data), 16'hF6);
      check($sformatf("bp_ready%0d", i), 16'(req_ready), 16'b00);
      tick();
    end
    check("bp_rsp_id", 16'(rsp_id), 16'd0);
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    #1;
    check("bp_valid_at_hs", 16'(rsp_valid), 16'd1);
    tick();
    check("bp_done", 16'(rsp_valid), 16'd0);

    // Reset mid-WAIT; pointer now sits on requester 1
    req_data = 16'h0040;
    req_op = 8'h03;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    check("rst_in_wait_data", 16'(alu_data), 16'h40);
    req_valid = 2'b11;
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    tick();
    reset = 1'b0;
    req_valid = 2'b00;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rsp_valid || alu_en) stray++;
      tick();
    end
    check("rst_no_response", 16'(stray), 16'd0);
    req_valid = 2'b11;
    #1;
    check("rst_ptr_grant", 16'(req_ready), 16'b01);
    tick();
    req_valid = 2'b00;
    wait_rsp("rst_after");
    check("rst_after_id", 16'(rsp_id), 16'd0);
    tick();

    // Latency: alu_y steps 11,22,33,44; only the LAT-th edge sample is 33
    y_mode = 1'b1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_rsp("lat");
    check("lat_rsp_data", 16'(rsp_data), 16'h33);
    tick();
    y_mode = 1'b0;

    // Lock: pointer on requester 1; it sends lock=1,1,0 while requester 0 stays valid
`ifdef ALU_SCHED_LOCK_EN
    exp_lock = '{1, 1, 1, 0};
`else
    exp_lock = '{1, 0, 1, 0};
`endif
    g_id.delete();
    r_id.delete();
    n1 = 0;
    req_valid = 2'b11;
    req_lock = 2'b10;
    for (int c = 0; c < 80 && r_id.size() < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        g_id.push_back(int'(req_ready[1]));
        if (req_ready[1]) n1++;
      end
      if (rsp_valid && rsp_ready) r_id.push_back(int'(rsp_id));
      tick();
      req_lock = {(n1 < 2), 1'b0};
      if (g_id.size() >= 4) req_valid = 2'b00;
    end
    check("lock_grant_count", 16'(g_id.size()), 16'd4);
    if (g_id.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("lock_grant%0d", i), 16'(g_id[i]), 16'(exp_lock[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
